// File: rtl/enc_bin2onehot_q_pkg.sv
// Shared constants and types for the binary to one-hot/thermometer encoder:
// mode encoding, error counter width, FIFO occupancy states.
package enc_bin2onehot_q_pkg;

    localparam logic MODE_ONEHOT = 1'b0;
    localparam logic MODE_THERMO = 1'b1;

    localparam int ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/enc_bin2onehot_q_if.sv
// Code-in / word-out handshake bundle of the encoder; slave is the encoder side.
interface enc_bin2onehot_q_if #(
    parameter int IN_W  = 4,
    parameter int OUT_N = 15
);
    import enc_bin2onehot_q_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [IN_W-1:0]      in;
    logic                 mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_N-1:0]     out;
    logic                 out_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport slave (
        input  in_valid, in, mode, out_ready,
        output in_ready, out_valid, out, out_err, err_cnt
    );

    modport master (
        output in_valid, in, mode, out_ready,
        input  in_ready, out_valid, out, out_err, err_cnt
    );

endinterface

// File: rtl/enc_skid2.sv
// Two-entry FIFO with fully registered outputs; push_ready never looks at pop_ready.
//
// state     | meaning
// OCC_EMPTY | no word held, pop_valid = 0
// OCC_ONE   | head holds the output word, tail free
// OCC_FULL  | head and tail both hold words, push_ready = 0
module enc_skid2
    import enc_bin2onehot_q_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data
);

    occ_e         occ;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         push;
    logic         pop;

    assign push     = push_valid && push_ready;
    assign pop      = pop_valid && pop_ready;
    assign pop_data = head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ        <= OCC_EMPTY;
            head       <= '0;
            tail       <= '0;
            push_ready <= 1'b0;
            pop_valid  <= 1'b0;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    // first edge after reset release lands here and opens the input
                    push_ready <= 1'b1;
                    if (push) begin
                        head      <= push_data;
                        occ       <= OCC_ONE;
                        pop_valid <= 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head <= push_data;
                    end else if (push) begin
                        tail       <= push_data;
                        occ        <= OCC_FULL;
                        push_ready <= 1'b0;
                    end else if (pop) begin
                        occ       <= OCC_EMPTY;
                        pop_valid <= 1'b0;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        head       <= tail;
                        occ        <= OCC_ONE;
                        push_ready <= 1'b1;
                    end
                end
                default: begin
                    occ        <= OCC_EMPTY;
                    push_ready <= 1'b0;
                    pop_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/enc_bin2onehot_q.sv
// Binary code to one-hot or thermometer word, queued through a two-entry FIFO,
// with a saturating count of out-of-range codes.
module enc_bin2onehot_q
    import enc_bin2onehot_q_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_N = 15
) (
    input  logic              clk,
    input  logic              rst,
    enc_bin2onehot_q_if.slave bus
);

    localparam logic [IN_W:0] LIMIT = (IN_W+1)'(OUT_N);

    logic [IN_W:0]    code_x;
    logic [OUT_N-1:0] dec_word;
    logic             dec_err;
    logic             push;
    logic [OUT_N:0]   fifo_out;

    // one extra bit so OUT_N = 2^IN_W still compares correctly
    assign code_x = {1'b0, bus.in};

    always_comb begin
        dec_word = '0;
        dec_err  = (code_x >= LIMIT);
        for (int k = 0; k < OUT_N; k++) begin
            if (bus.mode == MODE_THERMO) begin
                dec_word[k] = ((IN_W+1)'(k) < code_x);
            end else begin
                dec_word[k] = (code_x == (IN_W+1)'(k));
            end
        end
        if (dec_err) begin
            dec_word = '0;
        end
    end

    assign push = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.err_cnt <= '0;
        end else if (push && dec_err) begin
            bus.err_cnt <= sat_inc(bus.err_cnt);
        end
    end

    enc_skid2 #(
        .W(OUT_N + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_valid(bus.in_valid),
        .push_ready(bus.in_ready),
        .push_data ({dec_err, dec_word}),
        .pop_valid (bus.out_valid),
        .pop_ready (bus.out_ready),
        .pop_data  (fifo_out)
    );

    assign bus.out_err = fifo_out[OUT_N];
    assign bus.out     = fifo_out[OUT_N-1:0];

endmodule

// File: tb/tb_enc_bin2onehot_q.sv
// Directed bench for enc_bin2onehot_q: decode modes, range errors, back-pressure,
// streaming and reset behaviour.
module tb_enc_bin2onehot_q;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    enc_bin2onehot_q_if #(.IN_W(4), .OUT_N(15)) bus ();

    enc_bin2onehot_q #(.IN_W(4), .OUT_N(15)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b0;

        // reset state
        #3;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_out",       32'(bus.out),       32'd0);
        chk("rst_out_err",   32'(bus.out_err),   32'd0);
        chk("rst_err_cnt",   32'(bus.err_cnt),   32'd0);
        tick();
        rst = 1'b1;
        chk("rel_in_ready_low", 32'(bus.in_ready), 32'd0);
        tick();
        chk("rel_in_ready_high", 32'(bus.in_ready), 32'd1);

        // one-hot, code 5
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.mode      = 1'b0;
        bus.in        = 4'd5;
        tick();
        bus.in_valid = 1'b0;
        chk("oh5_out",       32'(bus.out),       32'h0020);
        chk("oh5_out_valid", 32'(bus.out_valid), 32'd1);
        chk("oh5_out_err",   32'(bus.out_err),   32'd0);
        tick();
        chk("oh5_drained", 32'(bus.out_valid), 32'd0);

        // thermometer, codes 3 and 0
        bus.in_valid = 1'b1;
        bus.mode     = 1'b1;
        bus.in       = 4'd3;
        tick();
        chk("th3_out", 32'(bus.out), 32'h0007);
        bus.in = 4'd0;
        tick();
        bus.in_valid = 1'b0;
        chk("th0_out",       32'(bus.out),       32'h0000);
        chk("th0_out_err",   32'(bus.out_err),   32'd0);
        chk("th0_out_valid", 32'(bus.out_valid), 32'd1);
        tick();
        chk("th0_drained", 32'(bus.out_valid), 32'd0);

        // out-of-range code in both modes
        bus.in_valid = 1'b1;
        bus.mode     = 1'b0;
        bus.in       = 4'd15;
        tick();
        chk("oor_oh_out",     32'(bus.out),     32'h0000);
        chk("oor_oh_out_err", 32'(bus.out_err), 32'd1);
        chk("oor_oh_err_cnt", 32'(bus.err_cnt), 32'd1);
        bus.mode = 1'b1;
        tick();
        chk("oor_th_out",     32'(bus.out),     32'h0000);
        chk("oor_th_out_err", 32'(bus.out_err), 32'd1);
        chk("oor_th_err_cnt", 32'(bus.err_cnt), 32'd2);
        for (int i = 0; i < 253; i++) tick();
        chk("err_cnt_255", 32'(bus.err_cnt), 32'd255);
        for (int i = 0; i < 45; i++) tick();
        bus.in_valid = 1'b0;
        chk("err_cnt_sat_300", 32'(bus.err_cnt), 32'd255);
        tick();

        // back-pressure: 1 and 2 fill the FIFO, 3 waits
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.mode      = 1'b0;
        bus.in        = 4'd1;
        tick();
        chk("bp_one_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_one_out",      32'(bus.out),      32'h0002);
        bus.in = 4'd2;
        tick();
        chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in = 4'd3;
        tick();
        chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_hold_out",      32'(bus.out),      32'h0002);
        chk("bp_hold_valid",    32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_pop1_out",      32'(bus.out),      32'h0004);
        chk("bp_pop1_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_code3_out", 32'(bus.out), 32'h0008);
        tick();
        chk("bp_drained", 32'(bus.out_valid), 32'd0);

        // streaming codes 0..14
        bus.in_valid = 1'b1;
        bus.mode     = 1'b0;
        for (int k = 0; k < 15; k++) begin
            bus.in = 4'(k);
            tick();
            chk($sformatf("stream_out_%0d", k), 32'(bus.out), 32'(1) << k);
            chk($sformatf("stream_rdy_%0d", k), 32'(bus.in_ready), 32'd1);
            chk($sformatf("stream_vld_%0d", k), 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        tick();

        // reset with FIFO full and err_cnt = 7
        rst = 1'b0;
        #1;
        rst = 1'b1;
        tick();
        chk("rst2_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in        = 4'd15;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        chk("pre_err_cnt",   32'(bus.err_cnt),   32'd7);
        chk("pre_in_ready",  32'(bus.in_ready),  32'd0);
        chk("pre_out_err",   32'(bus.out_err),   32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_out_err",   32'(bus.out_err),   32'd0);
        chk("mid_rst_err_cnt",   32'(bus.err_cnt),   32'd0);
        chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/enc_bin2onehot_q.md
ENC_BIN2ONEHOT_Q -- requirements
Module: enc_bin2onehot_q

Interface
REQ-001 The block SHALL provide parameter IN_W, default 4, meaning binary code width.
REQ-002 The block SHALL provide parameter OUT_N, default 15, meaning number of output lines; legal range 2..2^IN_W.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state rising-edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, upstream code valid.
REQ-006 The block SHALL have port in_ready, output, 1, block can accept a code.
REQ-007 The block SHALL have port in, input, IN_W, binary code.
REQ-008 The block SHALL have port mode, input, 1, 0 = one-hot, 1 = thermometer; sampled with in.
REQ-009 The block SHALL have port out_valid, output, 1, out holds a valid word.
REQ-010 The block SHALL have port out_ready, input, 1, downstream accepts out.
REQ-011 The block SHALL have port out, output, OUT_N, decoded word.
REQ-012 The block SHALL have port out_err, output, 1, current out word came from an out-of-range code.
REQ-013 The block SHALL have port err_cnt, output, 8, saturating count of accepted out-of-range codes.

Function
REQ-014 Input transfer SHALL occur on a clk edge with in_valid && in_ready; output transfer SHALL occur with out_valid && out_ready.
REQ-015 Decode SHALL be: one-hot out[k] = (in == k); thermometer out[k] = (k < in), for k = 0..OUT_N-1.
REQ-016 A code in >= OUT_N SHALL decode to out = all zeros, out_err = 1; in range SHALL give out_err = 0.
REQ-017 Decoded words SHALL pass through a 2-entry FIFO {out, out_err}; out/out_err/out_valid SHALL be driven from registers only.
REQ-018 Latency SHALL be 1 cycle: a code accepted at edge N is visible on out with out_valid = 1 after edge N when the FIFO was empty.
REQ-019 in_ready SHALL be a register, 1 when occupancy < 2 after the current edge's push/pop, and SHALL NOT depend combinationally on out_ready.
REQ-020 Occupancy states EMPTY(0), ONE(1), FULL(2); transitions: push only +1, pop only -1, push and pop in ONE stays ONE with the new word queued behind the popped one, neither holds.
REQ-021 In FULL, in_ready SHALL be 0; a pop SHALL move to ONE and raise in_ready at the same edge.
REQ-022 While out_valid = 1 and out_ready = 0, out and out_err SHALL hold stable.
REQ-023 Order SHALL be preserved; no word SHALL be dropped or duplicated.
REQ-024 err_cnt SHALL increment by 1 on each accepted out-of-range code and SHALL saturate at 255.
REQ-025 in and mode SHALL be ignored when no input transfer occurs.

Reset
REQ-026 On rst = 0, asynchronously: occupancy EMPTY, out_valid = 0, out = 0, out_err = 0, err_cnt = 0, in_ready = 0.
REQ-027 in_ready SHALL rise at the first clk edge after rst deasserts; a reset mid-transfer SHALL discard all queued words.

Structure
REQ-028 A shared package SHALL hold the mode encoding constants (MODE_ONEHOT = 0, MODE_THERMO = 1) and the err_cnt width constant (8).
REQ-029 The FIFO SHALL be a sub-module named enc_skid2 parametrised by data width (OUT_N+1); decode logic stays in enc_bin2onehot_q.

Verification
REQ-030 Defaults, mode 0, in = 5 accepted, out_ready = 1 -> next cycle out = 15'h0020, out_valid = 1, out_err = 0.
REQ-031 Mode 1, in = 3 -> out = 15'h0007; in = 0 -> out = 0, out_err = 0.
REQ-032 in = 15 (>= OUT_N), either mode -> out = 0, out_err = 1, err_cnt = 1; 300 such codes -> err_cnt = 255.
REQ-033 out_ready = 0, push codes 1, 2, 3 back-to-back -> only 1, 2 accepted, in_ready = 0 from the edge after the second push; release out_ready -> out = 0x0002 then 0x0004, then code 3 accepted -> 0x0008.
REQ-034 Continuous in_valid and out_ready = 1 with codes 0..14 -> one word per cycle, order intact, in_ready stays 1.
REQ-035 Assert rst = 0 with FULL FIFO and err_cnt = 7 -> out_valid, out_err, err_cnt all 0 immediately; in_ready = 1 one edge after release.
